// File: rtl/sum_reduce_seq.sv
// Sequential saturating reduction: latches N signed elements on start, then
// accumulates one element per clock with per-step saturation into a single sum.
module sum_reduce_seq #(
  parameter int WIDTH = 32,
  parameter int N     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [N*WIDTH-1:0] in_vec,
  output logic [WIDTH-1:0]   sum,
  output logic               overflow,
  output logic               valid,
  output logic               busy
);
  localparam int IDX_W = $clog2(N+1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N-1);
  localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {IDLE, ACC} state_t;

  state_t                  state, state_nxt;
  logic [N-1:0][WIDTH-1:0] ops;
  logic [IDX_W-1:0]        idx;
  logic [WIDTH-1:0]        acc, elem, acc_sat;
  logic [WIDTH:0]          wide;
  logic                    sticky, step_ovf, last;

  always_comb begin
    elem = '0;
    for (int i = 0; i < N; i++)
      if (idx == IDX_W'(i)) elem = ops[i];
  end

  // One guard bit is enough: the sign of the true sum is wide[WIDTH].
  always_comb begin
    wide     = {acc[WIDTH-1], acc} + {elem[WIDTH-1], elem};
    step_ovf = wide[WIDTH] ^ wide[WIDTH-1];
    acc_sat  = step_ovf ? (wide[WIDTH] ? MIN_V : MAX_V) : wide[WIDTH-1:0];
    last     = (idx == LAST_IDX);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACC;
      ACC:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb busy = (state == ACC);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ops      <= '0;
      idx      <= '0;
      acc      <= '0;
      sticky   <= 1'b0;
      sum      <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ops    <= in_vec;
          acc    <= '0;
          idx    <= '0;
          sticky <= 1'b0;
        end
        ACC: begin
          acc    <= acc_sat;
          idx    <= idx + 1'b1;
          sticky <= sticky | step_ovf;
          if (last) begin
            sum      <= acc_sat;
            overflow <= sticky | step_ovf;
            valid    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
